fetch_sequencer: RTL

//  Instruction-fetch / program-counter unit of the model computer. Holds the PC, reads the

---
 rtl/model_pkg.sv | 22 ++
 rtl/next_pc_calc.sv | 49 ++++
 rtl/fetch_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/model_pkg.sv
// Shared definitions for the model computer: next-PC select encodings,
// fetch FSM states and the opcode width.
package model_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned PCM_W = 3;

  localparam logic [PCM_W-1:0] PCM_SEQ  = 3'b000;
  localparam logic [PCM_W-1:0] PCM_REL  = 3'b001;
  localparam logic [PCM_W-1:0] PCM_ABS  = 3'b010;
  localparam logic [PCM_W-1:0] PCM_JZ   = 3'b011;
  localparam logic [PCM_W-1:0] PCM_JNZ  = 3'b100;
  localparam logic [PCM_W-1:0] PCM_HALT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection from the decoder's pc_mux/bias_mux controls.
// All arithmetic wraps modulo 2^ADDR_W.
module next_pc_calc
  import model_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMM_W  = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [PCM_W-1:0]  pc_mux,
  input  logic              bias_mux,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] next_pc,
  output logic              is_halt,
  output logic              is_illegal
);

  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] bias;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;

  assign imm_sext = ADDR_W'($signed(imm));
  assign bias     = bias_mux ? reg_data[ADDR_W-1:0] : imm_sext;
  assign pc_inc   = pc + ADDR_W'(1);
  assign pc_rel   = pc + bias;

  always_comb begin
    next_pc    = pc_inc;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (pc_mux)
      PCM_SEQ:  next_pc = pc_inc;
      PCM_REL:  next_pc = pc_rel;
      PCM_ABS:  next_pc = reg_data[ADDR_W-1:0];
      PCM_JZ:   next_pc = zero_flag ? pc_rel : pc_inc;
      PCM_JNZ:  next_pc = zero_flag ? pc_inc : pc_rel;
      PCM_HALT: begin
        next_pc = pc;
        is_halt = 1'b1;
      end
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / PC unit: two-cycle FETCH/EXEC loop that latches the
// instruction for the decoder and advances the PC from its select outputs.
module fetch_sequencer
  import model_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMM_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    stall,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [OP_W+IMM_W-1:0]   imem_rdata,
  output logic [OP_W-1:0]         op,
  output logic [IMM_W-1:0]        imm,
  output logic                    instr_valid,
  input  logic [PCM_W-1:0]        pc_mux,
  input  logic                    bias_mux,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic                    zero_flag,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted,
  output logic                    illegal
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] next_pc;
  logic              is_halt;
  logic              is_illegal;
  logic              pc_load;
  logic              ir_load;
  logic              illegal_next;

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_next_pc_calc (
    .pc         (pc),
    .pc_mux     (pc_mux),
    .bias_mux   (bias_mux),
    .imm        (imm),
    .reg_data   (reg_data),
    .zero_flag  (zero_flag),
    .next_pc    (next_pc),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // The memory is addressed straight from the PC register.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    illegal_next = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_next = ST_FETCH;
      ST_FETCH: begin
        ir_load    = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC:  if (!stall) begin
        pc_load      = !is_halt;
        illegal_next = is_illegal;
        state_next   = is_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered status flags, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      op          <= '0;
      imm         <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      if (pc_load) pc <= next_pc;
      if (ir_load) {op, imm} <= imem_rdata;
      instr_valid <= (state_next == ST_EXEC);
      halted      <= (state_next == ST_HALT);
      illegal     <= illegal_next;
    end
  end

endmodule
